path_delay_monitor: RTL

//   Sampled-time checker for the 4-input AND-tree cell (a,b,c,d -> out) and its specify paths.

---
 rtl/path_delay_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/path_delay_monitor.sv
// Sampled-time latency checker for a 4-input AND-tree cell: times each input toggle to the
// next output toggle and reports the measured delay against the per-input expected delay.
module path_delay_monitor #(
    parameter int CW       = 8,
    parameter int DLY_A    = 9,
    parameter int DLY_B    = 9,
    parameter int DLY_C    = 11,
    parameter int DLY_D    = 11,
    parameter int TOL      = 0,
    parameter int MAX_WAIT = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    in_sig,
    input  logic          out_sig,
    output logic          meas_valid,
    output logic [1:0]    meas_src,
    output logic [CW-1:0] meas_delay,
    output logic          meas_viol,
    output logic          meas_tmo,
    output logic          meas_ovl,
    output logic          spurious,
    output logic [7:0]    viol_count
);

    // Handshake: meas_valid is a one-cycle strobe with no back-pressure; the meas_* fields
    // are meaningful only while meas_valid=1 and are driven to zero otherwise.

    typedef enum logic [1:0] {IDLE, WAIT, REPORT} state_t;

    state_t        state, state_nx;
    logic [3:0]    in_q;
    logic          out_q;
    logic [3:0]    in_edge;
    logic          out_edge;
    logic [1:0]    src;
    logic [CW-1:0] cnt;
    logic [CW-1:0] delay;
    logic          tmo;
    logic          ovl;
    logic [CW-1:0] exp_dly;
    logic [CW:0]   abs_diff;
    logic          viol_now;

    assign in_edge  = in_sig ^ in_q;
    assign out_edge = out_sig ^ out_q;

    function automatic logic [1:0] lsb_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        exp_dly = CW'(DLY_A);
        case (src)
            2'd0: exp_dly = CW'(DLY_A);
            2'd1: exp_dly = CW'(DLY_B);
            2'd2: exp_dly = CW'(DLY_C);
            2'd3: exp_dly = CW'(DLY_D);
            default: exp_dly = CW'(DLY_A);
        endcase
    end

    // One extra bit so the absolute difference never wraps.
    always_comb begin
        abs_diff = '0;
        if (delay >= exp_dly) abs_diff = {1'b0, delay} - {1'b0, exp_dly};
        else                  abs_diff = {1'b0, exp_dly} - {1'b0, delay};
        viol_now = tmo | (abs_diff > (CW+1)'(TOL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_edge != 4'd0) state_nx = out_edge ? REPORT : WAIT;
            WAIT:    if (out_edge || cnt == CW'(MAX_WAIT)) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q       <= in_sig;
            out_q      <= out_sig;
            src        <= 2'd0;
            cnt        <= '0;
            delay      <= '0;
            tmo        <= 1'b0;
            ovl        <= 1'b0;
            meas_valid <= 1'b0;
            meas_src   <= 2'd0;
            meas_delay <= '0;
            meas_viol  <= 1'b0;
            meas_tmo   <= 1'b0;
            meas_ovl   <= 1'b0;
            spurious   <= 1'b0;
            viol_count <= 8'd0;
        end else begin
            in_q       <= in_sig;
            out_q      <= out_sig;
            meas_valid <= 1'b0;
            meas_src   <= 2'd0;
            meas_delay <= '0;
            meas_viol  <= 1'b0;
            meas_tmo   <= 1'b0;
            meas_ovl   <= 1'b0;
            spurious   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_edge != 4'd0) begin
                        src   <= lsb_idx(in_edge);
                        cnt   <= CW'(1);
                        ovl   <= (in_edge & (in_edge - 4'd1)) != 4'd0;
                        tmo   <= 1'b0;
                        delay <= '0;
                    end else if (out_edge) begin
                        spurious <= 1'b1;
                    end
                end
                WAIT: begin
                    // Edges arriving mid-measurement are flagged but never timed.
                    if (in_edge != 4'd0) ovl <= 1'b1;
                    if (out_edge) begin
                        delay <= cnt;
                    end else if (cnt == CW'(MAX_WAIT)) begin
                        delay <= '0;
                        tmo   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REPORT: begin
                    meas_valid <= 1'b1;
                    meas_src   <= src;
                    meas_delay <= delay;
                    meas_viol  <= viol_now;
                    meas_tmo   <= tmo;
                    meas_ovl   <= ovl;
                    if (viol_now && viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
